// File: rtl/steer_en_cmp.sv
// Load-cell compare pipeline and settle timer for the steering-enable state machine.
// Define LD_AVG_EN to average the last four samples per cell ahead of the compare stage.
module steer_en_cmp #(
   parameter bit          fast_sim     = 1'b0,
   parameter logic [12:0] MIN_RIDER_WT = 13'h200,
   parameter logic [12:0] HYSTERESIS   = 13'h040
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   input  logic        ld_vld,
   input  logic        clr_tmr,
   output logic        sum_gt_min,
   output logic        sum_lt_min,
   output logic        diff_gt_eigth,
   output logic        diff_gt_15_16,
   output logic        cmp_vld,
   output logic        tmr_full
);

   localparam logic [26:0] LIMIT = fast_sim ? 27'd32767 : 27'd64_999_999;

   localparam logic signed [13:0] UPPER =
      $signed({1'b0, MIN_RIDER_WT}) + $signed({1'b0, HYSTERESIS});
   localparam logic signed [13:0] LOWER_RAW =
      $signed({1'b0, MIN_RIDER_WT}) - $signed({1'b0, HYSTERESIS});
   // A negative lower limit clamps to 0, so sum_lt_min can never fire.
   localparam logic signed [13:0] LOWER = (LOWER_RAW < 14'sd0) ? 14'sd0 : LOWER_RAW;

   logic [11:0] lft_s1, rght_s1;
   logic        vld1_q, vld2_q;
   logic [12:0] sum_q, sum_d;
   logic [11:0] diff_q, diff_d;
   logic [26:0] tmr_cnt_q;

`ifdef LD_AVG_EN
   logic [3:0][11:0] lft_sr_q, rght_sr_q;
   logic [13:0]      lft_acc, rght_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_sr_q  <= '0;
         rght_sr_q <= '0;
      end else if (ld_vld) begin
         lft_sr_q  <= {lft_sr_q[2:0], lft_ld};
         rght_sr_q <= {rght_sr_q[2:0], rght_ld};
      end
   end

   always_comb begin
      lft_acc  = 14'(lft_sr_q[0]) + 14'(lft_sr_q[1]) + 14'(lft_sr_q[2]) + 14'(lft_sr_q[3]);
      rght_acc = 14'(rght_sr_q[0]) + 14'(rght_sr_q[1]) + 14'(rght_sr_q[2])
               + 14'(rght_sr_q[3]);
      lft_s1   = lft_acc[13:2];
      rght_s1  = rght_acc[13:2];
   end
`else
   logic [11:0] lft_q, rght_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_q  <= '0;
         rght_q <= '0;
      end else if (ld_vld) begin
         lft_q  <= lft_ld;
         rght_q <= rght_ld;
      end
   end

   assign lft_s1  = lft_q;
   assign rght_s1 = rght_q;
`endif

   always_comb begin
      sum_d  = {1'b0, lft_s1} + {1'b0, rght_s1};
      diff_d = (lft_s1 >= rght_s1) ? (lft_s1 - rght_s1) : (rght_s1 - lft_s1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1_q <= 1'b0;
         vld2_q <= 1'b0;
         sum_q  <= '0;
         diff_q <= '0;
      end else begin
         vld1_q <= ld_vld;
         vld2_q <= vld1_q;
         sum_q  <= sum_d;
         diff_q <= diff_d;
      end
   end

   logic signed [13:0] sum_s;
   logic [12:0]        sum_15_16;

   always_comb begin
      sum_s     = $signed({1'b0, sum_q});
      sum_15_16 = sum_q - (sum_q >> 4);
   end

   // Flags only move on a valid sample; otherwise they hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_gt_min    <= 1'b0;
         sum_lt_min    <= 1'b1;
         diff_gt_eigth <= 1'b0;
         diff_gt_15_16 <= 1'b0;
         cmp_vld       <= 1'b0;
      end else begin
         cmp_vld <= vld2_q;
         if (vld2_q) begin
            sum_gt_min    <= (sum_s > UPPER);
            sum_lt_min    <= (sum_s < LOWER);
            diff_gt_eigth <= ({1'b0, diff_q} > {3'b000, sum_q[12:3]});
            diff_gt_15_16 <= ({1'b0, diff_q} > sum_15_16);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_cnt_q <= '0;
      end else if (clr_tmr) begin
         tmr_cnt_q <= '0;
      end else if (tmr_cnt_q != LIMIT) begin
         tmr_cnt_q <= tmr_cnt_q + 27'd1;
      end
   end

   assign tmr_full = (tmr_cnt_q == LIMIT);

endmodule

// File: tb/tb_steer_en_cmp.sv
// Directed bench for steer_en_cmp (fast_sim timer): flags, latency, hold, back-to-back,
// mid-stream reset and timer saturation/clear.
module tb_steer_en_cmp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] lft_ld, rght_ld;
   logic        ld_vld, clr_tmr;
   logic        sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, cmp_vld, tmr_full;
   logic [4:0]  obs;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   steer_en_cmp #(
      .fast_sim     (1'b1),
      .MIN_RIDER_WT (13'h200),
      .HYSTERESIS   (13'h040)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .lft_ld        (lft_ld),
      .rght_ld       (rght_ld),
      .ld_vld        (ld_vld),
      .clr_tmr       (clr_tmr),
      .sum_gt_min    (sum_gt_min),
      .sum_lt_min    (sum_lt_min),
      .diff_gt_eigth (diff_gt_eigth),
      .diff_gt_15_16 (diff_gt_15_16),
      .cmp_vld       (cmp_vld),
      .tmr_full      (tmr_full)
   );

   // {cmp_vld, gt, lt, eighth, 15/16}
   assign obs = {cmp_vld, sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16};

   task automatic test_reset();
      rst_n   = 1'b0;
      ld_vld  = 1'b0;
      clr_tmr = 1'b0;
      lft_ld  = '0;
      rght_ld = '0;
      #12;
      checks++;
      if (obs !== 5'b00100) begin
         errors++;
         $display("FAIL reset_flags: got %b expected %b", obs, 5'b00100);
      end
      checks++;
      if (tmr_full !== 1'b0) begin
         errors++;
         $display("FAIL reset_tmr_full: got %b expected 0", tmr_full);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Single samples with full-latency, latency-early and hold checks.
   task automatic test_single(input string tname, input logic [11:0] l [],
                              input logic [11:0] r [], input logic [3:0] e []);
      for (int i = 0; i < l.size(); i++) begin
         @(negedge clk);
         lft_ld  = l[i];
         rght_ld = r[i];
         ld_vld  = 1'b1;
         @(negedge clk);
         ld_vld  = 1'b0;
         @(negedge clk);
         checks++;
         if (cmp_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s_early_vld[%0d]: got %b expected 0", tname, i, cmp_vld);
         end
         @(negedge clk);
         checks++;
         if (obs !== {1'b1, e[i]}) begin
            errors++;
            $display("FAIL %s_flags[%0d]: got %b expected %b", tname, i, obs, {1'b1, e[i]});
         end
         @(negedge clk);
         checks++;
         if (obs !== {1'b0, e[i]}) begin
            errors++;
            $display("FAIL %s_hold[%0d]: got %b expected %b", tname, i, obs, {1'b0, e[i]});
         end
      end
   endtask

   task automatic test_presence();
      // sums: 0x300, 0x240 (upper edge), 0x241, 0x1C0 (lower edge), 0x1BF, 0
      logic [11:0] l [] = '{12'h180, 12'h240, 12'h121, 12'h0E0, 12'h0E0, 12'h000};
      logic [11:0] r [] = '{12'h180, 12'h000, 12'h120, 12'h0E0, 12'h0DF, 12'h000};
      logic [3:0]  e [] = '{4'b1000, 4'b0011, 4'b1000, 4'b0000, 4'b0100, 4'b0100};
      test_single("presence", l, r, e);
   endtask

   task automatic test_diff();
      // diff 0x20 vs sum/8 0x44; diff 0x80 vs 0x50; diff 0x1C0 vs 15/16 0x1A4
      logic [11:0] l [] = '{12'h120, 12'h180, 12'h1C0};
      logic [11:0] r [] = '{12'h100, 12'h100, 12'h000};
      logic [3:0]  e [] = '{4'b0000, 4'b1010, 4'b0011};
      test_single("diff", l, r, e);
   endtask

   task automatic test_back_to_back();
      logic [11:0] l [4] = '{12'h180, 12'h240, 12'h120, 12'h180};
      logic [11:0] r [4] = '{12'h180, 12'h000, 12'h100, 12'h100};
      logic [3:0]  e [4] = '{4'b1000, 4'b0011, 4'b0000, 4'b1010};
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k >= 3 && k <= 6) begin
            checks++;
            if (obs !== {1'b1, e[k-3]}) begin
               errors++;
               $display("FAIL b2b_flags[%0d]: got %b expected %b", k - 3, obs, {1'b1, e[k-3]});
            end
         end else begin
            checks++;
            if (cmp_vld !== 1'b0) begin
               errors++;
               $display("FAIL b2b_idle_vld[%0d]: got %b expected 0", k, cmp_vld);
            end
         end
         if (k < 4) begin
            lft_ld  = l[k];
            rght_ld = r[k];
            ld_vld  = 1'b1;
         end else begin
            ld_vld  = 1'b0;
         end
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      lft_ld  = 12'h180;
      rght_ld = 12'h180;
      ld_vld  = 1'b1;
      @(negedge clk);
      lft_ld  = 12'h240;
      rght_ld = 12'h000;
      @(negedge clk);
      ld_vld  = 1'b0;
      rst_n   = 1'b0;
      #1;
      checks++;
      if (obs !== 5'b00100) begin
         errors++;
         $display("FAIL midreset_flags: got %b expected %b", obs, 5'b00100);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (cmp_vld !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale_vld[%0d]: got %b expected 0", k, cmp_vld);
         end
      end
      // Pipeline must still work after the reset.
      @(negedge clk);
      lft_ld  = 12'h180;
      rght_ld = 12'h180;
      ld_vld  = 1'b1;
      @(negedge clk);
      ld_vld  = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== 5'b11000) begin
         errors++;
         $display("FAIL midreset_recover: got %b expected %b", obs, 5'b11000);
      end
   endtask

   task automatic test_timer();
      @(negedge clk);
      clr_tmr = 1'b1;
      @(negedge clk);
      clr_tmr = 1'b0;
      repeat (32766) @(negedge clk);
      checks++;
      if (tmr_full !== 1'b0) begin
         errors++;
         $display("FAIL tmr_before_limit: got %b expected 0", tmr_full);
      end
      @(negedge clk);
      checks++;
      if (tmr_full !== 1'b1) begin
         errors++;
         $display("FAIL tmr_at_limit: got %b expected 1", tmr_full);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (tmr_full !== 1'b1) begin
         errors++;
         $display("FAIL tmr_saturate: got %b expected 1", tmr_full);
      end
      clr_tmr = 1'b1;
      @(negedge clk);
      checks++;
      if (tmr_full !== 1'b0) begin
         errors++;
         $display("FAIL tmr_clear_from_full: got %b expected 0", tmr_full);
      end
      clr_tmr = 1'b0;
      @(negedge clk);
      checks++;
      if (tmr_full !== 1'b0) begin
         errors++;
         $display("FAIL tmr_after_clear: got %b expected 0", tmr_full);
      end
      // Clear arrives on the edge that would have reached the limit.
      repeat (32765) @(negedge clk);
      clr_tmr = 1'b1;
      @(negedge clk);
      clr_tmr = 1'b0;
      checks++;
      if (tmr_full !== 1'b0) begin
         errors++;
         $display("FAIL tmr_clear_wins: got %b expected 0", tmr_full);
      end
   endtask

   initial begin
      test_reset();
      test_presence();
      test_diff();
      test_back_to_back();
      test_reset_midstream();
      test_timer();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
